// File: rtl/i2cs_apb_regfile.sv
// APB register file bridging an I2C slave: CTRL/STATUS/RXDATA/TXDATA registers over byte RX/TX FIFOs.
// Optional FIFO_LEVEL register at 0x010 is built only when I2CS_FIFO_LEVEL_EN is defined.
module i2cs_apb_regfile #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_wrenable,
  input  logic [11:0] reg_raddr,
  output logic [31:0] reg_rdata,
  input  logic        reg_rd_byte_complete,
  input  logic [7:0]  i2c_rx_data,
  input  logic        i2c_rx_valid,
  output logic [7:0]  i2c_tx_data,
  input  logic        i2c_tx_pop,
  output logic        i2c_tx_empty,
  output logic        enable_o,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_STATUS = 12'h004;
  localparam logic [11:0] A_RXDATA = 12'h008;
  localparam logic [11:0] A_TXDATA = 12'h00C;
`ifdef I2CS_FIFO_LEVEL_EN
  localparam logic [11:0] A_LEVEL  = 12'h010;
`endif

  logic [2:0]    r_ctrl;
  logic          r_rx_ovf;
  logic          r_irq;
  logic [11:0]   r_raddr_q;

  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [CW-1:0] r_tx_cnt;

  logic w_enable, w_wr_ctrl, w_wr_status, w_wr_txdata, w_flush;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rx_push_req, w_rx_push, w_rx_pop, w_ovf_set, w_ovf_clr;
  logic w_tx_push, w_tx_pop;
  logic [7:0] w_rx_head, w_tx_head;
  logic w_unused;

  assign w_enable    = r_ctrl[0];
  assign w_wr_ctrl   = reg_wrenable && (reg_waddr == A_CTRL);
  assign w_wr_status = reg_wrenable && (reg_waddr == A_STATUS);
  assign w_wr_txdata = reg_wrenable && (reg_waddr == A_TXDATA);
  // Disabling the block throws away anything still queued in either direction.
  assign w_flush     = w_wr_ctrl && w_enable && !reg_wdata[0];

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);

  assign w_rx_head = r_rx_mem[r_rx_rptr];
  assign w_tx_head = r_tx_mem[r_tx_rptr];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_rx_pop      = reg_rd_byte_complete && (r_raddr_q == A_RXDATA) && !w_rx_empty;
  assign w_rx_push_req = i2c_rx_valid && w_enable;
  assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);
  assign w_ovf_set     = w_rx_push_req && w_rx_full && !w_rx_pop;
  assign w_ovf_clr     = w_wr_status && reg_wdata[4];

  assign w_tx_pop  = i2c_tx_pop && !w_tx_empty;
  assign w_tx_push = w_wr_txdata && w_enable && (!w_tx_full || w_tx_pop);

  assign w_unused = ^reg_wdata[31:8];

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= i2c_rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= reg_wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else if (w_flush) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (w_rx_pop && !w_rx_push) r_rx_cnt <= r_rx_cnt - 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (w_tx_pop && !w_tx_push) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_rx_ovf  <= 1'b0;
      r_irq     <= 1'b0;
      r_raddr_q <= '0;
    end else begin
      r_raddr_q <= reg_raddr;
      if (w_wr_ctrl) r_ctrl <= reg_wdata[2:0];
      r_rx_ovf  <= w_ovf_set || (r_rx_ovf && !w_ovf_clr);
      r_irq     <= (r_ctrl[1] && !w_rx_empty) || (r_ctrl[2] && w_tx_empty && w_enable) || r_rx_ovf;
    end
  end

`ifdef I2CS_FIFO_LEVEL_EN
  logic [4:0] w_rx_lvl, w_tx_lvl;
  assign w_rx_lvl = 5'(r_rx_cnt);
  assign w_tx_lvl = 5'(r_tx_cnt);
`endif

  always_comb begin
    reg_rdata = '0;
    case (reg_raddr)
      A_CTRL:   reg_rdata = {29'b0, r_ctrl};
      A_STATUS: reg_rdata = {27'b0, r_rx_ovf, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
      A_RXDATA: reg_rdata = w_rx_empty ? 32'h0 : {24'b0, w_rx_head};
`ifdef I2CS_FIFO_LEVEL_EN
      A_LEVEL:  reg_rdata = {19'b0, w_tx_lvl, 3'b0, w_rx_lvl};
`endif
      default:  reg_rdata = '0;
    endcase
  end

  assign i2c_tx_data  = w_tx_empty ? 8'h00 : w_tx_head;
  assign i2c_tx_empty = w_tx_empty;
  assign enable_o     = w_enable;
  assign irq_o        = r_irq;

endmodule

// File: doc/i2cs_apb_regfile.md
I2CS_APB_REGFILE -- requirements
Module: i2cs_apb_regfile

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX/TX FIFO depth in bytes; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port reg_waddr  input  12  registered APB write byte address.
REQ-005 SHALL have port reg_wdata  input  32  registered APB write data.
REQ-006 SHALL have port reg_wrenable  input  1  one-cycle write strobe.
REQ-007 SHALL have port reg_raddr  input  12  live APB read byte address.
REQ-008 SHALL have port reg_rdata  output  32  read data, combinational from reg_raddr.
REQ-009 SHALL have port reg_rd_byte_complete  input  1  pulse one cycle after a completed read access.
REQ-010 SHALL have port i2c_rx_data  input  8  byte from I2C side.
REQ-011 SHALL have port i2c_rx_valid  input  1  push i2c_rx_data into RX FIFO.
REQ-012 SHALL have port i2c_tx_data  output  8  TX FIFO head byte; 0 when empty.
REQ-013 SHALL have port i2c_tx_pop  input  1  pop TX FIFO head.
REQ-014 SHALL have port i2c_tx_empty  output  1  TX FIFO empty.
REQ-015 SHALL have port enable_o  output  1  CTRL.enable.
REQ-016 SHALL have port irq_o  output  1  registered interrupt.

Function
REQ-017 SHALL decode registers: 0x000 CTRL RW [0]enable [1]rx_irq_en [2]tx_irq_en; 0x004 STATUS [0]rx_empty [1]rx_full [2]tx_empty [3]tx_full [4]rx_ovf (W1C); 0x008 RXDATA RO [7:0] RX head; 0x00C TXDATA WO [7:0] push.
REQ-018 SHALL read 0 for unmapped addresses, TXDATA, and RXDATA when RX empty; unmapped writes ignored.
REQ-019 SHALL apply a write in the cycle reg_wrenable=1; effect visible on reg_rdata the following cycle.
REQ-020 SHALL register reg_raddr every cycle and pop RX when reg_rd_byte_complete=1 and the registered address equals 0x008.
REQ-021 SHALL ignore RX pop when empty and TX pop when empty (no pointer/count change).
REQ-022 SHALL push RX only when enable=1; push when full is dropped and sets rx_ovf.
REQ-023 SHALL drop TXDATA writes when TX full or enable=0.
REQ-024 SHALL leave count unchanged on simultaneous push and pop of a non-empty FIFO; on a full FIFO the push still succeeds.
REQ-025 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-026 SHALL flush both FIFOs (pointers/counts to 0) in the cycle CTRL.enable is written 1->0.
REQ-027 SHALL give set priority over W1C clear when rx_ovf set and clear coincide.
REQ-028 SHALL drive irq_o next cycle = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty & enable) | rx_ovf.

Reset
REQ-029 SHALL on rst clear CTRL, rx_ovf, pointers, counts, registered raddr, irq_o; outputs reset to enable_o=0, irq_o=0, i2c_tx_empty=1, i2c_tx_data=0.
REQ-030 SHALL discard FIFO contents on reset asserted mid-transfer; no partial push/pop completes.

Configuration
REQ-031 SHALL with I2CS_FIFO_LEVEL_EN defined map 0x010 FIFO_LEVEL RO: [4:0] RX count, [12:8] TX count; without it 0x010 reads 0 and no level logic exists.

Verification
REQ-032 SHALL test: write CTRL=0x1, push RX 0xA5,0x3C -> RXDATA reads 0xA5 then 0x3C, STATUS[0]=1 after.
REQ-033 SHALL test: 9 RX pushes with depth 8 -> STATUS=0x16 (rx_full, tx_empty, rx_ovf); W1C 0x10 clears bit 4.
REQ-034 SHALL test: TXDATA writes 0x11,0x22, i2c_tx_pop twice -> i2c_tx_data 0x11,0x22, then i2c_tx_empty=1.
REQ-035 SHALL test: CTRL=0x3 with RX non-empty -> irq_o=1 one cycle later; CTRL 0x3->0x0 -> FIFOs flushed, irq_o=0.
REQ-036 SHALL test: simultaneous RX push and RXDATA pop at count 8 -> count stays 8, rx_ovf stays 0.
REQ-037 SHALL test: rst asserted with 3 bytes queued -> STATUS reads 0x05, FIFO_LEVEL reads 0 (macro defined).
